// File: rtl/seg7_scan.sv
// Scans a 16-bit value as four hex digits on an active-low 7-segment bus, blanking anodes at each slot start.
// New values are double-buffered and shown only from a frame boundary onward, so a frame never tears.
module seg7_scan #(
  parameter int REFRESH_W = 18,
  parameter int BLANK_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick,
  output logic        upd_pending
);

  localparam logic [REFRESH_W-1:0] CNT_MAX = '1;
  localparam logic [REFRESH_W-1:0] BLANK_C = REFRESH_W'(BLANK_CYC);

  logic [REFRESH_W-1:0] cnt_q;
  logic [1:0]           idx_q;
  logic [15:0]          disp_val_q, pend_val_q;
  logic [3:0]           disp_dp_q, pend_dp_q;
  logic [3:0]           disp_en_q, pend_en_q;
  logic                 upd_pending_q;
  logic [3:0]           an_q;
  logic [6:0]           seg_q;
  logic                 dp_q;
  logic                 frame_tick_q;

  logic       slot_end, frame_end;
  logic [3:0] nibble;
  logic       dark;
  logic [3:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign slot_end  = (cnt_q == CNT_MAX);
  assign frame_end = slot_end && (idx_q == 2'd3);

  // Outputs are computed from the pre-edge scan position, so every change lands on a slot start or in blanking.
  always_comb begin
    nibble = 4'(disp_val_q >> {idx_q, 2'b00});
    dark   = (cnt_q < BLANK_C) || !disp_en_q[idx_q];
    an_d   = 4'b1111;
    seg_d  = 7'h7F;
    dp_d   = 1'b1;
    if (!dark) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = hex7(nibble);
      dp_d  = ~disp_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= 2'd0;
      disp_val_q    <= 16'h0000;
      disp_dp_q     <= 4'h0;
      disp_en_q     <= 4'h0;
      pend_val_q    <= 16'h0000;
      pend_dp_q     <= 4'h0;
      pend_en_q     <= 4'h0;
      upd_pending_q <= 1'b0;
      an_q          <= 4'b1111;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      frame_tick_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_q + 1'b1;
      if (slot_end) idx_q <= idx_q + 2'd1;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_end;

      if (load) begin
        pend_val_q <= value;
        pend_dp_q  <= dp_in;
        pend_en_q  <= digit_en;
      end

      // A load coinciding with the boundary bypasses the buffer and cancels any older pending value.
      if (frame_end && load) begin
        disp_val_q    <= value;
        disp_dp_q     <= dp_in;
        disp_en_q     <= digit_en;
        upd_pending_q <= 1'b0;
      end else if (frame_end) begin
        if (upd_pending_q) begin
          disp_val_q <= pend_val_q;
          disp_dp_q  <= pend_dp_q;
          disp_en_q  <= pend_en_q;
        end
        upd_pending_q <= 1'b0;
      end else if (load) begin
        upd_pending_q <= 1'b1;
      end
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_tick  = frame_tick_q;
  assign upd_pending = upd_pending_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan with 16-cycle slots and 64-cycle frames.
module tb_seg7_scan;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
    logic       up;
  } obs_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;
  logic        upd_pending;

  int checks;
  int failures;

  obs_t exp_q[$];

  logic [6:0] hex_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference state: t counts clock edges since reset release; scan position is derived from it.
  int          t;
  logic [15:0] m_val, p_val;
  logic [3:0]  m_dp, p_dp, m_en, p_en;
  logic        m_up;

  seg7_scan #(.REFRESH_W(4), .BLANK_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_in(dp_in),
    .digit_en(digit_en), .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick),
    .upd_pending(upd_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    t = 0;
    m_val = '0; p_val = '0; m_dp = '0; p_dp = '0; m_en = '0; p_en = '0;
    m_up = 1'b0;
  endtask

  task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    int   c;
    int   i;
    bit   bnd;
    obs_t x;
    @(negedge clk);
    load = ld; value = v; dp_in = d; digit_en = e;
    c   = t % 16;
    i   = (t / 16) % 4;
    bnd = ((t % 64) == 63);
    x.ft = bnd;
    if (c < 2 || !m_en[i]) begin
      x.an = 4'b1111; x.seg = 7'h7F; x.dp = 1'b1;
    end else begin
      x.an  = ~(4'b0001 << i);
      x.seg = hex_lut[m_val[4*i +: 4]];
      x.dp  = ~m_dp[i];
    end
    if (bnd && ld) begin
      m_val = v; m_dp = d; m_en = e; m_up = 1'b0;
    end else if (bnd) begin
      if (m_up) begin
        m_val = p_val; m_dp = p_dp; m_en = p_en;
      end
      m_up = 1'b0;
    end else if (ld) begin
      m_up = 1'b1;
    end
    if (ld) begin
      p_val = v; p_dp = d; p_en = e;
    end
    x.up = m_up;
    exp_q.push_back(x);
    t++;
  endtask

  task automatic idle();
    step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic idle_until(input int phase);
    while ((t % 64) != phase) idle();
  endtask

  task automatic check_dark(input string name);
    obs_t got;
    got = '{an: an, seg: seg, dp: dp, ft: frame_tick, up: upd_pending};
    checks++;
    if (got !== '{an: 4'hF, seg: 7'h7F, dp: 1'b1, ft: 1'b0, up: 1'b0}) begin
      failures++;
      $display("FAIL %s: got an=%b seg=%h dp=%b ft=%b up=%b, want an=1111 seg=7f dp=1 ft=0 up=0",
               name, an, seg, dp, frame_tick, upd_pending);
    end
  endtask

  // Monitor: the DUT presents one observation per clock edge.
  initial begin
    obs_t e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = '{an: an, seg: seg, dp: dp, ft: frame_tick, up: upd_pending};
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL scan t=%0t: got an=%b seg=%h dp=%b ft=%b up=%b, want an=%b seg=%h dp=%b ft=%b up=%b",
                   $time, got.an, got.seg, got.dp, got.ft, got.up, e.an, e.seg, e.dp, e.ft, e.up);
        end
        checks++;
        if ($countones(~an) > 1) begin
          failures++;
          $display("FAIL one_anode t=%0t: got an=%b, want at most one low", $time, an);
        end
      end
    end
  end

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; digit_en = '0;
    model_reset();
    #12;
    check_dark("reset_state");
    @(posedge clk); #3;
    rst_n = 1'b1;

    // 1: idle scanning stays dark, frame_tick every 64 cycles
    repeat (100) idle();

    // 2: mid-frame load, applied at next boundary
    idle_until(20);
    step(1'b1, 16'hA8F0, 4'b0100, 4'b1111);
    repeat (140) idle();

    // 3: last load in a frame wins
    idle_until(10);
    step(1'b1, 16'h1234, 4'b0000, 4'b1111);
    idle_until(30);
    step(1'b1, 16'h5678, 4'b0000, 4'b1111);
    repeat (140) idle();

    // 4: load on the boundary edge bypasses the pending buffer
    idle_until(40);
    step(1'b1, 16'h0000, 4'b1111, 4'b1111);
    idle_until(63);
    step(1'b1, 16'hFFFF, 4'b0000, 4'b1111);
    repeat (80) idle();

    // 5: partially enabled digits
    idle_until(5);
    step(1'b1, 16'h9999, 4'b0000, 4'b0101);
    repeat (150) idle();

    // 6: async reset mid-slot on digit 2
    idle_until(40);
    @(posedge clk); #3;
    load = 1'b0;
    rst_n = 1'b0;
    #1;
    check_dark("async_reset");
    repeat (3) @(posedge clk);
    #3;
    check_dark("held_reset");
    model_reset();
    rst_n = 1'b1;
    repeat (70) idle();

    // Random loads with random bus contents between them
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 29) == 0)
        step(1'b1, 16'($urandom), 4'($urandom), 4'($urandom));
      else
        idle();
    end

    @(posedge clk); #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
